// File: rtl/bpsk_symbol_modulator.sv
// BPSK modulator: a sine table drives the carrier, and each accepted symbol either keeps it or inverts its sign.
// Every symbol starts at phase 0, so polarity flips only at zero crossings of the carrier.
module bpsk_symbol_modulator #(
    parameter int OUT_W       = 12,
    parameter int LUT_DEPTH   = 32,
    parameter int CYC_PER_SYM = 4,
    parameter int DIFF_EN     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sym_valid,
    input  logic             sym_in,
    output logic             sym_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             underrun
);
    localparam int PW = $clog2(LUT_DEPTH);
    localparam int CW = (CYC_PER_SYM > 1) ? $clog2(CYC_PER_SYM) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(LUT_DEPTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_SYM - 1);

    // sin(pi*2m/LUT_DEPTH) in Q30, for m in 0..LUT_DEPTH/4, by Taylor series in integers
    function automatic longint sin_q30(input int m);
        longint x, term, sum;
        x    = (64'sd3373259426 * 2 * longint'(m)) / longint'(LUT_DEPTH);
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Quadrant folding keeps the series argument within [0, pi/2]
    function automatic logic signed [OUT_W-1:0] lut_val(input int k);
        int     q, r, m;
        longint amp, v;
        q   = k / (LUT_DEPTH / 4);
        r   = k % (LUT_DEPTH / 4);
        m   = (q % 2 == 1) ? (LUT_DEPTH / 4 - r) : r;
        amp = (longint'(1) <<< (OUT_W - 1)) - 1;
        v   = (amp * sin_q30(m) + (longint'(1) <<< 29)) >>> 30;
        if (q >= 2) v = -v;
        return v[OUT_W-1:0];
    endfunction

    logic signed [OUT_W-1:0] lut [LUT_DEPTH];
    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        localparam logic signed [OUT_W-1:0] LV = lut_val(g);
        assign lut[g] = LV;
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_n;
    logic [PW-1:0]           phase, phase_n;
    logic [CW-1:0]           cyc, cyc_n;
    logic                    bit_r, bit_n;
    logic                    prev_tx, prev_n;
    logic                    out_valid_n, underrun_n;
    logic [OUT_W-1:0]        out_n;
    logic signed [OUT_W-1:0] sample;
    logic                    last, accept, tx_bit;

    assign last      = (phase == PH_LAST) && (cyc == CYC_LAST);
    assign sym_ready = en && !rst && (state == IDLE || (state == RUN && last));
    assign accept    = sym_valid && sym_ready;
    assign tx_bit    = (DIFF_EN != 0) ? (sym_in ^ prev_tx) : sym_in;
    assign sample    = bit_r ? lut[phase] : -lut[phase];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            cyc       <= '0;
            bit_r     <= 1'b0;
            prev_tx   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            cyc       <= cyc_n;
            bit_r     <= bit_n;
            prev_tx   <= prev_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            underrun  <= underrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        phase_n     = phase;
        cyc_n       = cyc;
        bit_n       = bit_r;
        prev_n      = prev_tx;
        out_n       = out;
        out_valid_n = out_valid;
        underrun_n  = underrun;
        if (en) begin
            underrun_n  = 1'b0;
            out_valid_n = (state == RUN);
            out_n       = (state == RUN) ? sample : '0;
            if (accept) begin
                state_n = RUN;
                phase_n = '0;
                cyc_n   = '0;
                bit_n   = tx_bit;
                prev_n  = tx_bit;
            end else if (state == RUN) begin
                if (last) begin
                    state_n    = IDLE;
                    underrun_n = 1'b1;
                end else begin
                    phase_n = phase + 1'b1;
                    if (phase == PH_LAST) cyc_n = cyc + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bpsk_symbol_modulator.sv
// Bench for bpsk_symbol_modulator: plain and differential instances share one stimulus stream
// and are compared each cycle against a sample-index model built on a real-valued sine table.
module tb_bpsk_symbol_modulator;
    localparam int D  = 8;
    localparam int C  = 2;
    localparam int W  = 12;
    localparam int SL = D * C;

    logic         clk = 1'b0;
    logic         rst = 1'b1, en = 1'b0, sym_valid = 1'b0, sym_in = 1'b0;
    logic         rdy0, rdy1, ov0, ov1, ur0, ur1;
    logic [W-1:0] o0, o1;

    always #5 clk = ~clk;

    bpsk_symbol_modulator #(.OUT_W(W), .LUT_DEPTH(D), .CYC_PER_SYM(C), .DIFF_EN(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sym_valid(sym_valid), .sym_in(sym_in),
        .sym_ready(rdy0), .out(o0), .out_valid(ov0), .underrun(ur0));
    bpsk_symbol_modulator #(.OUT_W(W), .LUT_DEPTH(D), .CYC_PER_SYM(C), .DIFF_EN(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sym_valid(sym_valid), .sym_in(sym_in),
        .sym_ready(rdy1), .out(o1), .out_valid(ov1), .underrun(ur1));

    int errors = 0;
    int checks = 0;
    int L[D];
    int lit[D] = '{0, 1447, 2047, 1447, 0, -1447, -2047, -1447};

    // model: busy flag, sample index within the symbol, transmitted bits
    bit m_busy = 0, m_b0 = 0, m_b1 = 0, m_p1 = 0, m_acc = 0;
    int m_s = 0;
    int e_out0 = 0, e_out1 = 0;
    bit e_vld = 0, e_und = 0, e_rdy = 0;
    // observations of the latest step
    int s_out0, s_out1;
    bit s_vld, s_und, s_rdy;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v, input bit d);
        @(negedge clk);
        rst = r; en = e; sym_valid = v; sym_in = d;
        #1;
        e_rdy = !r && e && (!m_busy || m_s == SL - 1);
        s_rdy = rdy0;
        check("sym_ready", int'(rdy0), int'(e_rdy));
        check("sym_ready_diff", int'(rdy1), int'(e_rdy));
        m_acc = 0;
        if (r) begin
            m_busy = 0; m_s = 0; m_b0 = 0; m_b1 = 0; m_p1 = 0;
            e_out0 = 0; e_out1 = 0; e_vld = 0; e_und = 0;
        end else if (e) begin
            e_und  = 0;
            e_vld  = m_busy;
            e_out0 = m_busy ? (m_b0 ? L[m_s % D] : -L[m_s % D]) : 0;
            e_out1 = m_busy ? (m_b1 ? L[m_s % D] : -L[m_s % D]) : 0;
            if (v && e_rdy) begin
                m_acc = 1; m_busy = 1; m_s = 0;
                m_b0 = d; m_b1 = d ^ m_p1; m_p1 = m_b1;
            end else if (m_busy) begin
                if (m_s == SL - 1) begin m_busy = 0; e_und = 1; end
                else m_s++;
            end
        end
        @(posedge clk);
        #1;
        s_out0 = int'($signed(o0));
        s_out1 = int'($signed(o1));
        s_vld  = ov0;
        s_und  = ur0;
        check("out", s_out0, e_out0);
        check("out_diff", s_out1, e_out1);
        check("out_valid", int'(ov0), int'(e_vld));
        check("out_valid_diff", int'(ov1), int'(e_vld));
        check("underrun", int'(ur0), int'(e_und));
        check("underrun_diff", int'(ur1), int'(e_und));
    endtask

    initial begin
        int q0[$];
        int q1[$];
        int n, ucount, vcount;
        bit bits3[3] = '{1'b1, 1'b0, 1'b1};
        bit bits4[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int pol0[4] = '{1, 1, -1, -1};
        int pol1[4] = '{1, -1, -1, -1};
        bit r, e, v, d;

        for (int k = 0; k < D; k++) begin
            real x;
            x = 2047.0 * $sin(2.0 * 3.14159265358979 * k / D);
            L[k] = $rtoi(x + ((x >= 0.0) ? 0.5 : -0.5));
            check("table", L[k], lit[k]);
        end

        // reset then idle
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("ready_in_reset", int'(s_rdy), 0);
        repeat (4) step(0, 1, 0, 0);
        check("ready_idle", int'(s_rdy), 1);

        // single symbol, bit 1
        step(0, 1, 1, 1);
        ucount = 0;
        repeat (20) begin
            step(0, 1, 0, 0);
            if (s_vld) q0.push_back(s_out0);
            if (s_und) ucount++;
        end
        check("t2_len", q0.size(), 16);
        for (int k = 0; k < q0.size() && k < 16; k++) check("t2_sample", q0[k], lit[k % D]);
        check("t2_underrun", ucount, 1);

        // back-to-back stream 1,0,1
        q0.delete();
        step(0, 1, 1, bits3[0]);
        n = 1;
        for (int c = 0; c < 52; c++) begin
            step(0, 1, n < 3, (n < 3) ? bits3[n] : 1'b0);
            if (c <= 46) check("t3_ready", int'(s_rdy), int'(c == 15 || c == 31));
            if (m_acc) n++;
            if (s_vld) q0.push_back(s_out0);
        end
        check("t3_len", q0.size(), 48);
        for (int k = 0; k < q0.size() && k < 48; k++)
            check("t3_sample", q0[k], (k / 16 == 1) ? -lit[k % D] : lit[k % D]);

        // differential: inputs 1,1,0,0 from clean history
        step(1, 1, 0, 0);
        q0.delete();
        q1.delete();
        step(0, 1, 1, bits4[0]);
        n = 1;
        for (int c = 0; c < 68; c++) begin
            step(0, 1, n < 4, (n < 4) ? bits4[n] : 1'b0);
            if (m_acc) n++;
            if (s_vld) begin q0.push_back(s_out0); q1.push_back(s_out1); end
        end
        check("t4_len", q1.size(), 64);
        for (int s = 0; s < 4; s++) begin
            if (q1.size() == 64) begin
                check("t4_pol_diff", q1[16 * s + 2], pol1[s] * 2047);
                check("t4_pol_plain", q0[16 * s + 2], pol0[s] * 2047);
            end
        end

        // freeze for 3 cycles after sample 5
        step(0, 1, 1, 1);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            step(0, 1, 0, 0);
            if (s_vld) vcount++;
        end
        repeat (3) begin
            step(0, 0, 0, 0);
            check("t5_hold", s_out0, -1447);
            check("t5_hold_valid", int'(s_vld), 1);
        end
        step(0, 1, 0, 0);
        if (s_vld) vcount++;
        check("t5_resume", s_out0, -2047);
        repeat (12) begin
            step(0, 1, 0, 0);
            if (s_vld) vcount++;
        end
        check("t5_count", vcount, 16);

        // reset mid-symbol at sample 9
        step(0, 1, 1, 1);
        repeat (10) step(0, 1, 0, 0);
        check("t6_pre", s_out0, 1447);
        step(1, 1, 0, 0);
        check("t6_out", s_out0, 0);
        check("t6_valid", int'(s_vld), 0);
        check("t6_underrun", int'(s_und), 0);
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        check("t6_restart0", s_out0, 0);
        check("t6_restart_valid", int'(s_vld), 1);
        step(0, 1, 0, 0);
        check("t6_restart1", s_out0, 1447);
        repeat (20) step(0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) < 8);
            v = ($urandom_range(0, 9) < 6);
            d = $urandom_range(0, 1) == 1;
            step(r, e, v, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
